// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer: single owner of the HD44780 4-bit LCD pins.
// Runs power-up initialisation, then round-robin arbitrates byte writes
// from two requesters and serialises each byte as two E-strobed nibbles.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// POR_WAIT  | power-on settle time before the first init nibble
// INIT      | load the next init ROM nibble, then strobe it
// IDLE      | init complete; waiting for a request to arbitrate
// NIB_SETUP | RS/DATA driven, E low (setup time)
// NIB_E     | E high
// NIB_HOLD  | E low again, RS/DATA held (controller execution time)
// CLR_WAIT  | long wait after a clear/home command
module lcd_write_sequencer #(
    parameter int SETUP_CYCLES = 2,
    parameter int E_CYCLES     = 800,
    parameter int POR_CYCLES   = 300000,
    parameter int CLR_CYCLES   = 60000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       rs0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic       rs1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [3:0] lcd_data,
    output logic       init_done,
    output logic       busy
);

    // One shared phase counter; sized for the longest wait. The nibble
    // phases are assumed to be shorter than the POR/clear waits.
    localparam int MAX_WAIT = (POR_CYCLES > CLR_CYCLES) ? POR_CYCLES : CLR_CYCLES;
    localparam int CW       = $clog2(MAX_WAIT + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] E_LAST     = CW'(E_CYCLES - 1);
    localparam logic [CW-1:0] POR_LAST   = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYCLES - 1);
    localparam logic [3:0]    INIT_LAST  = 4'd11;

    typedef enum logic [2:0] {
        POR_WAIT,
        INIT,
        IDLE,
        NIB_SETUP,
        NIB_E,
        NIB_HOLD,
        CLR_WAIT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [3:0]    init_idx;
    logic          lo_nib;
    logic          byte_rs;
    logic [7:0]    byte_val;
    logic          last_grant;

    logic          accept;
    logic          grant;
    logic          is_clr;
    logic [3:0]    nib_cur;
    logic          rs_cur;

    // Init sequence: three 0x3 wake-ups, 0x2 for 4-bit mode, then the
    // function-set / display-on / entry-mode / clear bytes split in nibbles.
    function automatic logic [3:0] init_nibble(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd2: init_nibble = 4'h3;
            4'd3, 4'd4:       init_nibble = 4'h2;
            4'd5:             init_nibble = 4'h8;
            4'd7:             init_nibble = 4'hC;
            4'd9:             init_nibble = 4'h6;
            4'd11:            init_nibble = 4'h1;
            default:          init_nibble = 4'h0;
        endcase
    endfunction

    // Nibble to put on the pins: init ROM until init completes, else the
    // latched byte, high nibble first.
    always_comb begin
        is_clr  = !byte_rs && ((byte_val == 8'h01) || (byte_val == 8'h02));
        nib_cur = 4'h0;
        rs_cur  = 1'b0;
        if (!init_done) begin
            nib_cur = init_nibble(init_idx);
        end else begin
            nib_cur = lo_nib ? byte_val[3:0] : byte_val[7:4];
            rs_cur  = byte_rs;
        end
    end

    // Next-state logic and round-robin arbitration.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        grant      = 1'b0;
        case (state)
            POR_WAIT: begin
                if (cnt == POR_LAST) state_next = INIT;
            end
            INIT: begin
                state_next = NIB_SETUP;
            end
            IDLE: begin
                if (init_done && (req0 || req1)) begin
                    accept     = 1'b1;
                    grant      = req1 && (!req0 || !last_grant);
                    state_next = NIB_SETUP;
                end
            end
            NIB_SETUP: begin
                if (cnt == SETUP_LAST) state_next = NIB_E;
            end
            NIB_E: begin
                if (cnt == E_LAST) state_next = NIB_HOLD;
            end
            NIB_HOLD: begin
                if (cnt == E_LAST) begin
                    if (!init_done) begin
                        // the last init nibble completes the 0x01 clear
                        state_next = (init_idx == INIT_LAST) ? CLR_WAIT : INIT;
                    end else if (!lo_nib) begin
                        state_next = NIB_SETUP;
                    end else begin
                        state_next = is_clr ? CLR_WAIT : IDLE;
                    end
                end
            end
            CLR_WAIT: begin
                if (cnt == CLR_LAST) state_next = IDLE;
            end
            default: begin
                state_next = POR_WAIT;
            end
        endcase
    end

    // State register and phase counter; the counter restarts on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= POR_WAIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state) ? '0 : cnt + CW'(1);
        end
    end

    // Byte latch, nibble/init progress and arbitration history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_idx   <= 4'd0;
            lo_nib     <= 1'b0;
            byte_rs    <= 1'b0;
            byte_val   <= 8'h00;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                byte_rs    <= grant ? rs1 : rs0;
                byte_val   <= grant ? data1 : data0;
                last_grant <= grant;
                lo_nib     <= 1'b0;
            end else if (state == NIB_HOLD && state_next == NIB_SETUP) begin
                lo_nib <= 1'b1;
            end
            if (state == NIB_HOLD && state_next == INIT) begin
                init_idx <= init_idx + 4'd1;
            end
        end
    end

    // Registered pin and status outputs. E follows the state by one cycle;
    // RS/DATA load during setup so they lead E and hold through the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 4'h0;
            init_done <= 1'b0;
            busy      <= 1'b1;
        end else begin
            ack0  <= accept && !grant;
            ack1  <= accept && grant;
            lcd_e <= (state == NIB_E);
            if (state == NIB_SETUP) begin
                lcd_data <= nib_cur;
                lcd_rs   <= rs_cur;
            end
            busy <= (state_next != IDLE);
            if (state_next == IDLE) init_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed bench for lcd_write_sequencer with short timing parameters:
// SETUP=1, E=4, POR=10, CLR=20 -> nibble 9 cycles, byte 18 cycles.
module tb_lcd_write_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, rs0, ack0;
    logic       req1, rs1, ack1;
    logic [7:0] data0, data1;
    logic       lcd_rs, lcd_e, init_done, busy;
    logic [3:0] lcd_data;

    lcd_write_sequencer #(
        .SETUP_CYCLES(1),
        .E_CYCLES    (4),
        .POR_CYCLES  (10),
        .CLR_CYCLES  (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .rs0      (rs0),
        .data0    (data0),
        .ack0     (ack0),
        .req1     (req1),
        .rs1      (rs1),
        .data1    (data1),
        .ack1     (ack1),
        .lcd_rs   (lcd_rs),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data),
        .init_done(init_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Bus monitor: cycle count, E pulses with their RS/DATA, widths, rise cycle.
    int         cyc = 0;
    logic [4:0] nib_q[$];
    int         wid_q[$];
    int         rise_q[$];
    int         e_w = 0;
    logic       e_prev = 1'b0;
    logic [4:0] e_val = 5'h0;
    int         unstable = 0;
    int         both_ack = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (lcd_e && !e_prev) begin
            e_val = {lcd_rs, lcd_data};
            nib_q.push_back(e_val);
            rise_q.push_back(cyc);
            e_w = 1;
        end else if (lcd_e) begin
            e_w++;
            if ({lcd_rs, lcd_data} != e_val) unstable++;
        end else if (e_prev) begin
            wid_q.push_back(e_w);
        end
        if (ack0 && ack1) both_ack++;
        e_prev = lcd_e;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        nib_q.delete();
        wid_q.delete();
        rise_q.delete();
    endtask

    // Waits for the given ack; returns the cycle it was seen, or -1.
    task automatic wait_ack(input int port, input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if ((port == 0 && ack0) || (port == 1 && ack1)) begin
                at = cyc;
                break;
            end
        end
        chk($sformatf("ack%0d_seen", port), (at >= 0), 1);
    endtask

    task automatic wait_idle(input string tag, input int bound, output int n);
        n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic check_widths(input string tag);
        int bad;
        bad = 0;
        foreach (wid_q[i]) if (wid_q[i] != 4) bad++;
        chk({tag, "_e_width"}, bad, 0);
    endtask

    task automatic check_init_nibs(input string tag);
        logic [3:0] exp_nib[12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                    4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};
        chk({tag, "_nib_count"}, nib_q.size() >= 12, 1);
        for (int i = 0; i < 12; i++) begin
            if (i < nib_q.size())
                chk($sformatf("%s_nib%0d", tag, i), nib_q[i], {1'b0, exp_nib[i]});
        end
    endtask

    initial begin
        int rel, n, t, a;
        int n0, n1;
        int gnt_port[$];
        int gnt_cyc[$];
        int exp_gnt[4]   = '{1, 0, 1, 0};
        logic [4:0] exp3[8] = '{5'h15, 5'h10, 5'h13, 5'h10, 5'h15, 5'h11, 5'h13, 5'h11};
        logic [4:0] exp4[4] = '{5'h00, 5'h01, 5'h14, 5'h12};
        int busy_low_cyc, ack0_cyc, pre_ack;
        logic done_seen;

        rst = 1'b1;
        req0 = 1'b0; rs0 = 1'b0; data0 = 8'h00;
        req1 = 1'b0; rs1 = 1'b0; data1 = 8'h00;
        repeat (3) tick();

        // Reset values
        chk("rst_lcd_rs", lcd_rs, 0);
        chk("rst_lcd_e", lcd_e, 0);
        chk("rst_lcd_data", lcd_data, 0);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_busy", busy, 1);

        // 1: power-up init with no requests
        clear_mon();
        rst = 1'b0;
        rel = cyc;
        n = 0;
        while (!init_done && n < 400) begin
            tick();
            n++;
        end
        chk("s1_init_done", init_done, 1);
        chk("s1_busy", busy, 0);
        chk("s1_min_time", (n >= 10 + 12 * 9 + 20), 1);
        chk("s1_por_wait", (rise_q.size() > 0) && (rise_q[0] - rel > 10), 1);
        chk("s1_pulses", nib_q.size(), 12);
        check_init_nibs("s1");
        check_widths("s1");

        // 2: single data write 0x41 on port 0
        clear_mon();
        rs0 = 1'b1; data0 = 8'h41; req0 = 1'b1;
        wait_ack(0, 10, t);
        req0 = 1'b0;
        chk("s2_ack_latency", t - rel - n, 1);
        chk("s2_busy_on_ack", busy, 1);
        tick();
        chk("s2_ack_one_cycle", ack0, 0);
        wait_idle("s2", 40, n);
        chk("s2_busy_cycles", n + 1, 18);
        chk("s2_pulses", nib_q.size(), 2);
        if (nib_q.size() == 2) begin
            chk("s2_nib_hi", nib_q[0], 5'h14);
            chk("s2_nib_lo", nib_q[1], 5'h11);
            chk("s2_rise_hi", rise_q[0] - t, 2);
            chk("s2_rise_lo", rise_q[1] - t, 11);
        end
        check_widths("s2");

        // 3: both ports contending; port 0 was last granted so port 1 leads
        clear_mon();
        rs0 = 1'b1; data0 = 8'h30; req0 = 1'b1;
        rs1 = 1'b1; data1 = 8'h50; req1 = 1'b1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 200 && (req0 || req1); i++) begin
            tick();
            if (ack0) begin
                gnt_port.push_back(0); gnt_cyc.push_back(cyc); n0++;
                if (n0 == 2) req0 = 1'b0; else data0 = 8'h31;
            end
            if (ack1) begin
                gnt_port.push_back(1); gnt_cyc.push_back(cyc); n1++;
                if (n1 == 2) req1 = 1'b0; else data1 = 8'h51;
            end
        end
        wait_idle("s3", 40, n);
        chk("s3_grants", gnt_port.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < gnt_port.size())
                chk($sformatf("s3_grant%0d", i), gnt_port[i], exp_gnt[i]);
            if (i > 0 && i < gnt_cyc.size())
                chk($sformatf("s3_gap%0d", i), gnt_cyc[i] - gnt_cyc[i-1], 19);
        end
        chk("s3_both_ack", both_ack, 0);
        chk("s3_pulses", nib_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < nib_q.size())
                chk($sformatf("s3_nib%0d", i), nib_q[i], exp3[i]);
        end
        check_widths("s3");

        // 4: clear command on port 1, port 0 request arrives during CLR_WAIT
        clear_mon();
        rs1 = 1'b0; data1 = 8'h01; req1 = 1'b1;
        wait_ack(1, 10, t);
        req1 = 1'b0;
        busy_low_cyc = -1;
        ack0_cyc = -1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (cyc == t + 25) begin
                rs0 = 1'b1; data0 = 8'h42; req0 = 1'b1;
            end
            if (!busy && busy_low_cyc < 0) busy_low_cyc = cyc;
            if (ack0) begin
                ack0_cyc = cyc;
                req0 = 1'b0;
                break;
            end
        end
        chk("s4_idle_after_clr", busy_low_cyc - t, 38);
        chk("s4_ack0_after_clr", ack0_cyc - t, 39);
        wait_idle("s4", 40, n);
        chk("s4_pulses", nib_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < nib_q.size())
                chk($sformatf("s4_nib%0d", i), nib_q[i], exp4[i]);
        end
        check_widths("s4");

        // 5: reset in the middle of an E pulse
        rs0 = 1'b1; data0 = 8'h48; req0 = 1'b1;
        wait_ack(0, 10, a);
        req0 = 1'b0;
        n = 0;
        while (!lcd_e && n < 20) begin
            tick();
            n++;
        end
        chk("s5_e_high", lcd_e, 1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("s5_async_e", lcd_e, 0);
        chk("s5_init_done", init_done, 0);
        chk("s5_busy", busy, 1);

        // 6: request pending across the whole re-initialisation
        rs0 = 1'b1; data0 = 8'h55; req0 = 1'b1;
        tick();
        tick();
        clear_mon();
        rst = 1'b0;
        pre_ack = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (ack0) pre_ack++;
            if (init_done) begin
                done_seen = 1'b1;
                break;
            end
        end
        chk("s6_init_done", done_seen, 1);
        chk("s6_no_early_ack", pre_ack, 0);
        chk("s6_busy_first_idle", busy, 0);
        tick();
        chk("s6_ack_after_init", ack0, 1);
        req0 = 1'b0;
        wait_idle("s6", 40, n);
        chk("s6_pulses", nib_q.size(), 14);
        check_init_nibs("s6");
        if (nib_q.size() == 14) begin
            chk("s6_nib_hi", nib_q[12], 5'h15);
            chk("s6_nib_lo", nib_q[13], 5'h15);
        end
        check_widths("s6");
        chk("rs_data_stable", unstable, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got %0d expected 0", cyc);
        $fatal(1);
    end

endmodule
